rob_retire_ctrl: RTL

In-order retirement controller for the N-way reorder buffer. Each cycle it examines the oldest N ROB entries and computes num_retiring under completion, store-port and control-flow limits. It sequences branch-mispredict recovery by restoring the ROB tail and squashing the pipeline, and it latches processor halt. It sits between the ROB head outputs and the retire/commit stage.

---
 rtl/rob_retire_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: in-order retirement controller for an N-way reorder buffer.
//
// Each cycle in RUN it scans the oldest N ROB entries (entry 0 oldest) and
// reports how many retire. The scan stops at the first entry that is
// incomplete or would exceed the store-commit budget. A retiring mispredict or
// halt is always the last entry retired that cycle.
//
// A retiring mispredict latches its tail checkpoint. The next cycle is a
// one-cycle FLUSH that drives tail_restore_valid and flush. RECOVER_CYCLES
// quiet cycles in RECOVER follow, then the controller returns to RUN.
// A retiring halt parks the controller in HALTED until reset.
//
// Ports:
//   clock, reset_n        clock (rising edge), async active-low reset
//   rob_outputs_valid     number of valid head entries
//   head_complete         per-entry: finished execution
//   head_is_store         per-entry: store
//   head_mispredict       per-entry: mispredicted branch
//   head_halt             per-entry: halt instruction
//   head_tail_ckpt        per-entry ROB tail checkpoint
//   sq_free_ports         store-commit slots available this cycle
//   num_retiring          entries retired this cycle (combinational)
//   tail_restore_valid    ROB tail restore strobe (registered)
//   tail_restore          tail value to restore (registered)
//   flush                 pipeline squash, coincident with tail_restore_valid
//   halted                sticky halt flag
//   retire_stall_cnt      saturating count of stalled RUN cycles

module rob_retire_ctrl #(
    parameter int unsigned N              = 3,
    parameter int unsigned ROB_SZ         = 32,
    parameter int unsigned ST_PORTS       = 1,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [$clog2(N+1)-1:0]                 rob_outputs_valid,
    input  logic [N-1:0]                           head_complete,
    input  logic [N-1:0]                           head_is_store,
    input  logic [N-1:0]                           head_mispredict,
    input  logic [N-1:0]                           head_halt,
    input  logic [N-1:0][$clog2(ROB_SZ)-1:0]       head_tail_ckpt,
    input  logic [$clog2(ST_PORTS+1)-1:0]          sq_free_ports,
    output logic [$clog2(N+1)-1:0]                 num_retiring,
    output logic                                   tail_restore_valid,
    output logic [$clog2(ROB_SZ)-1:0]              tail_restore,
    output logic                                   flush,
    output logic                                   halted,
    output logic [31:0]                            retire_stall_cnt
);

    localparam int unsigned CW  = $clog2(N+1);
    localparam int unsigned RB  = $clog2(ROB_SZ);
    localparam int unsigned RCW = 4;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StRecover,
        StHalted
    } state_e;

    state_e         state_q, state_d;
    logic [RB-1:0]  tail_q, tail_d;
    logic [RCW-1:0] rec_q, rec_d;
    logic [31:0]    stall_q, stall_d;

    // Scan results
    int            scan_cnt;
    int            st_cnt;
    int            st_lim;
    logic          stop;
    logic          mis_hit;
    logic          halt_hit;
    logic [RB-1:0] mis_ckpt;

    always_comb begin
        scan_cnt = 0;
        st_cnt   = 0;
        stop     = 1'b0;
        mis_hit  = 1'b0;
        halt_hit = 1'b0;
        mis_ckpt = '0;
        st_lim   = (int'(sq_free_ports) < int'(ST_PORTS)) ? int'(sq_free_ports)
                                                            : int'(ST_PORTS);
        for (int i = 0; i < int'(N); i++) begin
            if (!stop && (i < int'(rob_outputs_valid))) begin
                if (head_complete[i] && (!head_is_store[i] || (st_cnt + 1 <= st_lim))) begin
                    scan_cnt = scan_cnt + 1;
                    if (head_is_store[i]) begin
                        st_cnt = st_cnt + 1;
                    end
                    // Halt wins over mispredict on the same entry: no restore.
                    if (head_halt[i]) begin
                        halt_hit = 1'b1;
                        stop     = 1'b1;
                    end else if (head_mispredict[i]) begin
                        mis_hit  = 1'b1;
                        mis_ckpt = head_tail_ckpt[i];
                        stop     = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Gated with reset_n because the reset state is RUN.
    assign num_retiring = (reset_n && (state_q == StRun)) ? CW'(scan_cnt) : '0;

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        rec_d   = rec_q;
        stall_d = stall_q;
        unique case (state_q)
            StRun: begin
                if ((rob_outputs_valid != '0) && (scan_cnt == 0) && (stall_q != '1)) begin
                    stall_d = stall_q + 32'd1;
                end
                if (halt_hit) begin
                    state_d = StHalted;
                end else if (mis_hit) begin
                    state_d = StFlush;
                    tail_d  = mis_ckpt;
                end
            end
            StFlush: begin
                state_d = StRecover;
                rec_d   = RCW'(RECOVER_CYCLES);
            end
            StRecover: begin
                rec_d = rec_q - RCW'(1);
                // Leave on the last quiet cycle so RUN resumes right after.
                if (rec_q <= RCW'(1)) begin
                    state_d = StRun;
                    rec_d   = '0;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            tail_q  <= '0;
            rec_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            rec_q   <= rec_d;
            stall_q <= stall_d;
        end
    end

    assign tail_restore_valid = (state_q == StFlush);
    assign flush              = (state_q == StFlush);
    assign tail_restore       = tail_q;
    assign halted             = (state_q == StHalted);
    assign retire_stall_cnt   = stall_q;

endmodule
